// File: rtl/bus_scanner_pkg.sv
`default_nettype none
// bus_scanner_pkg: FSM state type, width helpers and mask search shared by the bus scanner.
package bus_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int SETTLE_W = 4;
  localparam int MAX_SRC  = 16;

  function automatic int src_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // First set bit at or above 'from'; returns MAX_SRC when none is found.
  function automatic logic [4:0] find_set(input logic [MAX_SRC-1:0] mask,
                                          input logic [4:0] from);
    logic [4:0] r;
    logic       found;
    r     = 5'(MAX_SRC);
    found = 1'b0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (!found && (5'(i) >= from) && mask[i]) begin
        r     = 5'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_scanner_onehot_decode.sv
`default_nettype none
// onehot_decode: index to one-hot enable vector; en low forces every bit to zero.
module onehot_decode #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot[i] = en && (idx == W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/bus_scanner.sv
`default_nettype none
// bus_scanner: enables one tri-state bus source at a time, samples it and hands it downstream.
// Optional source masking is built when BUS_SCANNER_SRC_MASK_EN is defined.
module bus_scanner
  import bus_scanner_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [WIDTH-1:0]             bus_in,
  input  logic                         ready,
`ifdef BUS_SCANNER_SRC_MASK_EN
  input  logic [NUM_SRC-1:0]           src_mask,
`endif
  output logic [NUM_SRC-1:0]           oe,
  output logic [WIDTH-1:0]             data_out,
  output logic [src_w(NUM_SRC)-1:0]    src_id,
  output logic                         valid,
  output logic                         busy,
  output logic                         done
);

  localparam int                  SRC_W       = src_w(NUM_SRC);
  localparam logic [SRC_W-1:0]    LAST_IDX    = SRC_W'(NUM_SRC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE);

  state_t              state, state_nx;
  logic [SRC_W-1:0]    idx, idx_nx, src_id_nx;
  logic [SETTLE_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0]    data_nx;
  logic                valid_nx, done_nx, oe_en;
  logic [NUM_SRC-1:0]  oe_nx;

  logic                start_ok, has_next, can_wrap;
  logic [SRC_W-1:0]    first_idx, next_idx, wrap_idx;

`ifdef BUS_SCANNER_SRC_MASK_EN
  logic [NUM_SRC-1:0]  mask, mask_nx;
  logic [4:0]          nxt_raw, first_raw;

  // Within a pass the stored mask steers the walk; the live mask is only used at start/wrap.
  always_comb begin
    nxt_raw   = find_set(MAX_SRC'(mask), 5'(idx) + 5'd1);
    first_raw = find_set(MAX_SRC'(src_mask), 5'd0);
  end

  assign start_ok  = |src_mask;
  assign has_next  = (nxt_raw < 5'(NUM_SRC));
  assign next_idx  = SRC_W'(nxt_raw);
  assign can_wrap  = continuous && (|src_mask);
  assign first_idx = SRC_W'(first_raw);
  assign wrap_idx  = SRC_W'(first_raw);
`else
  assign start_ok  = 1'b1;
  assign has_next  = (idx != LAST_IDX);
  assign next_idx  = idx + SRC_W'(1);
  assign can_wrap  = continuous;
  assign first_idx = '0;
  assign wrap_idx  = '0;
`endif

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    data_nx   = data_out;
    src_id_nx = src_id;
    valid_nx  = valid;
    done_nx   = 1'b0;
`ifdef BUS_SCANNER_SRC_MASK_EN
    mask_nx   = mask;
`endif
    case (state)
      IDLE: begin
        if (start && start_ok) begin
          state_nx = DRIVE;
          idx_nx   = first_idx;
          cnt_nx   = '0;
`ifdef BUS_SCANNER_SRC_MASK_EN
          mask_nx  = src_mask;
`endif
        end
      end
      DRIVE: begin
        if (cnt == SETTLE_LAST) begin
          data_nx   = bus_in;
          src_id_nx = idx;
          valid_nx  = 1'b1;
          cnt_nx    = '0;
          state_nx  = HOLD;
        end else begin
          cnt_nx = cnt + SETTLE_W'(1);
        end
      end
      HOLD: begin
        if (ready) begin
          valid_nx = 1'b0;
          if (has_next) begin
            idx_nx   = next_idx;
            state_nx = DRIVE;
          end else if (can_wrap) begin
            idx_nx   = wrap_idx;
            state_nx = DRIVE;
`ifdef BUS_SCANNER_SRC_MASK_EN
            mask_nx  = src_mask;
`endif
          end else begin
            idx_nx   = '0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // oe is registered from the next state so it never glitches and drops on the sampling edge.
  assign oe_en = (state_nx == DRIVE);

  onehot_decode #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_onehot_decode (
    .idx    (idx_nx),
    .en     (oe_en),
    .onehot (oe_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      data_out <= '0;
      src_id   <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      oe       <= '0;
`ifdef BUS_SCANNER_SRC_MASK_EN
      mask     <= '0;
`endif
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      cnt      <= cnt_nx;
      data_out <= data_nx;
      src_id   <= src_id_nx;
      valid    <= valid_nx;
      done     <= done_nx;
      oe       <= oe_nx;
`ifdef BUS_SCANNER_SRC_MASK_EN
      mask     <= mask_nx;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_scanner.sv
`default_nettype none
// tb_bus_scanner: directed scoreboard bench; a SETTLE=1 scanner plus SETTLE=3 and SETTLE=0 copies.
module tb_bus_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, continuous, ready, start_x, rdy_x, cont_x;
  logic [7:0] bus_m, data_m, bus3, data3, bus0, data0;
  logic [3:0] oe_m, oe3, oe0;
  logic [1:0] sid_m, sid3, sid0;
  logic       valid_m, busy_m, done_m, valid3, busy3, done3, valid0, busy0, done0;
  logic [3:0] win3, win0;
  logic [7:0] src_val [4];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [9:0] exp_q [3][$];
  int         last_x [3];
  int         oe_run [3];
  int         xfer_cnt [3];
  int         done_cnt [3];
  bit         per_chk;
  int         d0, x0, n;

  bus_scanner #(.NUM_SRC(4), .WIDTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .bus_in(bus_m),
    .ready(ready), .oe(oe_m), .data_out(data_m), .src_id(sid_m), .valid(valid_m),
    .busy(busy_m), .done(done_m));

  bus_scanner #(.NUM_SRC(4), .WIDTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_x), .continuous(cont_x), .bus_in(bus3),
    .ready(rdy_x), .oe(oe3), .data_out(data3), .src_id(sid3), .valid(valid3),
    .busy(busy3), .done(done3));

  bus_scanner #(.NUM_SRC(4), .WIDTH(8), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_x), .continuous(cont_x), .bus_in(bus0),
    .ready(rdy_x), .oe(oe0), .data_out(data0), .src_id(sid0), .valid(valid0),
    .busy(busy0), .done(done0));

  function automatic logic [1:0] enc(input logic [3:0] o);
    case (o)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Counter bank models; the aux buses expose cycles-into-window so sample timing is visible.
  always_comb begin
    if (oe_m == 4'b0)        bus_m = 8'hEE;
    else if (!$onehot(oe_m)) bus_m = 8'hFF;
    else                     bus_m = src_val[enc(oe_m)];
    bus3 = (oe3 == 4'b0) ? 8'hEE : {2'b00, enc(oe3), win3};
    bus0 = (oe0 == 4'b0) ? 8'hEE : {2'b00, enc(oe0), win0};
  end

  always @(posedge clk) begin
    win3 <= (oe3 != 4'b0) ? win3 + 4'd1 : 4'd0;
    win0 <= (oe0 != 4'b0) ? win0 + 4'd1 : 4'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input int settle, input bit chk_per, input logic [3:0] o,
                     input logic v, input logic r, input logic [1:0] sid, input logic [7:0] d,
                     input logic dn);
    logic [9:0] e;
    check($sformatf("k%0d_oe_onehot0", k), 32'($onehot0(o)), 32'd1);
    if (v) check($sformatf("k%0d_oe_off_in_hold", k), 32'(o), 32'd0);
    if (o != 4'b0) oe_run[k]++;
    else if (oe_run[k] > 0) begin
      check($sformatf("k%0d_oe_width", k), oe_run[k], settle + 1);
      oe_run[k] = 0;
    end
    if (v && r) begin
      if (chk_per && last_x[k] >= 0) check($sformatf("k%0d_period", k), cyc - last_x[k], settle + 2);
      last_x[k] = cyc;
      xfer_cnt[k]++;
      if (exp_q[k].size() == 0) check($sformatf("k%0d_unexpected_xfer", k), exp_q[k].size(), 1);
      else begin
        e = exp_q[k].pop_front();
        check($sformatf("k%0d_src_id", k), 32'(sid), 32'(e[9:8]));
        check($sformatf("k%0d_data_out", k), 32'(d), 32'(e[7:0]));
      end
    end
    if (dn) begin
      done_cnt[k]++;
      check($sformatf("k%0d_done_after_last", k), cyc - last_x[k], 1);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 3; k++) oe_run[k] = 0;
    end else begin
      mon(0, 1, per_chk, oe_m, valid_m, ready, sid_m, data_m, done_m);
      mon(1, 3, 1'b1, oe3, valid3, rdy_x, sid3, data3, done3);
      mon(2, 0, 1'b1, oe0, valid0, rdy_x, sid0, data0, done0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int i, input logic [7:0] d);
    exp_q[k].push_back({2'(i), d});
  endtask

  task automatic wait_done(input int k, input int dref, input int budget);
    int c = 0;
    while (done_cnt[k] == dref && c < budget) begin step(); c++; end
    repeat (3) step();
    check($sformatf("k%0d_done_pulses", k), done_cnt[k] - dref, 1);
  endtask

  task automatic wait_oe(input int b, input int budget);
    int c = 0;
    while (!oe_m[b] && c < budget) begin step(); c++; end
    check("wait_oe_reached", 32'(oe_m[b]), 32'd1);
  endtask

  initial begin
    src_val = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int k = 0; k < 3; k++) begin
      last_x[k] = -1; oe_run[k] = 0; xfer_cnt[k] = 0; done_cnt[k] = 0;
    end
    rst = 1'b1; start = 1'b0; continuous = 1'b0; ready = 1'b1;
    start_x = 1'b0; rdy_x = 1'b1; cont_x = 1'b0; per_chk = 1'b1;
    repeat (3) step();
    check("rst_oe", 32'(oe_m), 32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_data", 32'(data_m), 32'd0);
    check("rst_src_id", 32'(sid_m), 32'd0);
    rst = 1'b0;
    step();

    // Single-shot scan with ready always high, including first-sample latency.
    d0 = done_cnt[0]; last_x[0] = -1;
    for (int i = 0; i < 4; i++) push(0, i, src_val[i]);
    start = 1'b1; step(); start = 1'b0;
    check("t1_busy", 32'(busy_m), 32'd1);
    check("t1_oe_first", 32'(oe_m), 32'b0001);
    step();
    check("t1_valid_early", 32'(valid_m), 32'd0);
    check("t1_oe_settle", 32'(oe_m), 32'b0001);
    step();
    check("t1_valid_lat", 32'(valid_m), 32'd1);
    check("t1_oe_turnaround", 32'(oe_m), 32'd0);
    wait_done(0, d0, 40);
    check("t1_queue_empty", exp_q[0].size(), 0);
    check("t1_idle", 32'(busy_m), 32'd0);

    // Backpressure on source 2.
    per_chk = 1'b0; d0 = done_cnt[0]; last_x[0] = -1;
    for (int i = 0; i < 4; i++) push(0, i, src_val[i]);
    start = 1'b1; step(); start = 1'b0;
    wait_oe(2, 20);
    ready = 1'b0;
    n = 0;
    while (!valid_m && n < 10) begin step(); n++; end
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", 32'(valid_m), 32'd1);
      check("t2_hold_data", 32'(data_m), 32'h30);
      check("t2_hold_sid", 32'(sid_m), 32'd2);
      check("t2_hold_oe", 32'(oe_m), 32'd0);
      step();
    end
    ready = 1'b1;
    step();
    check("t2_src3_starts", 32'(oe_m), 32'b1000);
    wait_done(0, d0, 40);
    check("t2_queue_empty", exp_q[0].size(), 0);
    per_chk = 1'b1;

    // Continuous scan; continuous dropped during source 1 of the second pass.
    d0 = done_cnt[0]; x0 = xfer_cnt[0]; last_x[0] = -1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) push(0, i, src_val[i]);
    continuous = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (xfer_cnt[0] - x0 < 5 && n < 60) begin step(); n++; end
    check("t3_no_done_while_cont", done_cnt[0] - d0, 0);
    check("t3_busy_after_wrap", 32'(busy_m), 32'd1);
    check("t3_second_pass_src1", 32'(oe_m), 32'b0010);
    continuous = 1'b0;
    wait_done(0, d0, 40);
    check("t3_xfers", xfer_cnt[0] - x0, 8);
    check("t3_queue_empty", exp_q[0].size(), 0);

    // Reset during DRIVE on source 2, then a fresh scan from source 0.
    d0 = done_cnt[0]; last_x[0] = -1;
    push(0, 0, src_val[0]); push(0, 1, src_val[1]);
    start = 1'b1; step(); start = 1'b0;
    wait_oe(2, 20);
    rst = 1'b1;
    step();
    check("t4_rst_oe", 32'(oe_m), 32'd0);
    check("t4_rst_valid", 32'(valid_m), 32'd0);
    check("t4_rst_busy", 32'(busy_m), 32'd0);
    check("t4_rst_done", 32'(done_m), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    check("t4_no_done", done_cnt[0] - d0, 0);
    check("t4_queue_empty", exp_q[0].size(), 0);
    last_x[0] = -1;
    for (int i = 0; i < 4; i++) push(0, i, src_val[i]);
    start = 1'b1; step(); start = 1'b0;
    check("t4_restart_src0", 32'(oe_m), 32'b0001);
    wait_done(0, d0, 40);
    check("t4_restart_queue_empty", exp_q[0].size(), 0);

    // SETTLE=3 and SETTLE=0 copies: capture must be the bus value in the last oe-high cycle.
    for (int i = 0; i < 4; i++) begin
      push(1, i, {2'b00, 2'(i), 4'h3});
      push(2, i, {2'b00, 2'(i), 4'h0});
    end
    d0 = done_cnt[1]; x0 = done_cnt[2];
    start_x = 1'b1; step(); start_x = 1'b0;
    check("t5_s3_oe_first", 32'(oe3), 32'b0001);
    check("t5_s0_oe_first", 32'(oe0), 32'b0001);
    step();
    check("t5_s0_oe_one_cycle", 32'(oe0), 32'd0);
    check("t5_s0_valid", 32'(valid0), 32'd1);
    check("t5_s3_oe_still", 32'(oe3), 32'b0001);
    n = 0;
    while ((done_cnt[1] == d0 || done_cnt[2] == x0) && n < 80) begin step(); n++; end
    repeat (3) step();
    check("t5_s3_done", done_cnt[1] - d0, 1);
    check("t5_s0_done", done_cnt[2] - x0, 1);
    check("t5_s3_queue_empty", exp_q[1].size(), 0);
    check("t5_s0_queue_empty", exp_q[2].size(), 0);
    check("t5_idle", 32'({busy3, busy0}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
